// File: rtl/gpmc_pkg.sv
// Shared definitions for the GPMC asynchronous slave: bus width and cycle FSM encoding.
package gpmc_pkg;

    localparam int AD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_DRIVE = 3'd4,
        ST_DONE     = 3'd5
    } gpmc_state_e;

endpackage

// File: rtl/gpmc_sync.sv
// Multi-flop synchronizer for one asynchronous GPMC control pin, with rise/fall
// pulses derived from the synchronized level only.
module gpmc_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Shift the pin through the chain; prev_r is the synced level one cycle back
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {STAGES{RST_VAL}};
            prev_r  <= RST_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign q    = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/gpmc_async_slave.sv
// GPMC async address/data-multiplexed slave: turns host write16/read16 cycles into
// single-cycle register strobes. The pad tristate (oe ? ad_out : 'z) lives one level up.
module gpmc_async_slave
    import gpmc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gpmc_csn,
    input  logic              gpmc_advn,
    input  logic              gpmc_oen,
    input  logic              gpmc_wen,
    input  logic [1:0]        gpmc_ben,
    input  logic [15:0]       gpmc_ad_in,
    output logic [15:0]       gpmc_ad_out,
    output logic              gpmc_ad_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_stb,
    output logic [15:0]       reg_wr_data,
    output logic [1:0]        reg_wr_be,
    output logic              reg_rd_stb,
    input  logic [15:0]       reg_rd_data
);

    logic csn_s, advn_s, oen_s, wen_s;
    logic csn_rise_s, csn_fall_s, advn_rise_s, advn_fall_s;
    logic wen_rise_s, wen_fall_s, oen_rise_s, oen_fall_s;
    logic unused_s;

    gpmc_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rst(rst), .d(gpmc_csn), .q(csn_s), .rise(csn_rise_s), .fall(csn_fall_s));
    gpmc_sync #(.STAGES(SYNC_STAGES)) u_sync_advn (
        .clk(clk), .rst(rst), .d(gpmc_advn), .q(advn_s), .rise(advn_rise_s), .fall(advn_fall_s));
    gpmc_sync #(.STAGES(SYNC_STAGES)) u_sync_oen (
        .clk(clk), .rst(rst), .d(gpmc_oen), .q(oen_s), .rise(oen_rise_s), .fall(oen_fall_s));
    gpmc_sync #(.STAGES(SYNC_STAGES)) u_sync_wen (
        .clk(clk), .rst(rst), .d(gpmc_wen), .q(wen_s), .rise(wen_rise_s), .fall(wen_fall_s));

    // CS release is handled on the synced level, so the edge pulses of these are spare
    assign unused_s = ^{csn_rise_s, csn_fall_s, advn_fall_s, wen_fall_s, oen_rise_s};

    logic [AD_W-1:0] ad_dly_r  [SYNC_STAGES];
    logic [1:0]      ben_dly_r [SYNC_STAGES];
    logic [AD_W-1:0] ad_al_s;
    logic [1:0]      ben_al_s;

    // Data delay line of the same depth as the control synchronizers keeps AD aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_dly_r[i]  <= {AD_W{1'b0}};
                ben_dly_r[i] <= 2'b11;
            end
        end else begin
            ad_dly_r[0]  <= gpmc_ad_in;
            ben_dly_r[0] <= gpmc_ben;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_dly_r[i]  <= ad_dly_r[i-1];
                ben_dly_r[i] <= ben_dly_r[i-1];
            end
        end
    end

    assign ad_al_s  = ad_dly_r[SYNC_STAGES-1];
    assign ben_al_s = ben_dly_r[SYNC_STAGES-1];

    gpmc_state_e       state_r, state_nxt_s;
    logic [2:0]        lat_cnt_r;
    logic              lat_done_s, drive_ok_s;
    logic              addr_go_s, wr_go_s, rd_go_s, drive_go_s;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wr_data_r, ad_out_r;
    logic [1:0]        wr_be_r;
    logic              wr_stb_r, rd_stb_r, ad_oe_r;

    assign lat_done_s = (lat_cnt_r == 3'(RD_LATENCY));
    // The bus may only be driven while the host is reading: WE and ADV both released
    assign drive_ok_s = ~oen_s & wen_s & advn_s;

    // Next-state logic; synced CS high anywhere but DONE abandons the cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!csn_s && !advn_s) state_nxt_s = ST_ADDR;
                else                   state_nxt_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (csn_s)            state_nxt_s = ST_IDLE;
                else if (advn_rise_s) state_nxt_s = ST_ACTIVE;
                else                  state_nxt_s = ST_ADDR;
            end
            ST_ACTIVE: begin
                if (csn_s)           state_nxt_s = ST_IDLE;
                else if (wen_rise_s) state_nxt_s = ST_DONE;
                else if (oen_fall_s) state_nxt_s = ST_RD_WAIT;
                else                 state_nxt_s = ST_ACTIVE;
            end
            ST_RD_WAIT: begin
                if (csn_s)            state_nxt_s = ST_IDLE;
                else if (!drive_ok_s) state_nxt_s = ST_DONE;
                else if (lat_done_s)  state_nxt_s = ST_RD_DRIVE;
                else                  state_nxt_s = ST_RD_WAIT;
            end
            ST_RD_DRIVE: begin
                if (csn_s)            state_nxt_s = ST_IDLE;
                else if (!drive_ok_s) state_nxt_s = ST_DONE;
                else                  state_nxt_s = ST_RD_DRIVE;
            end
            ST_DONE: begin
                if (csn_s) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign addr_go_s  = (state_r == ST_ADDR)    && (state_nxt_s == ST_ACTIVE);
    assign wr_go_s    = (state_r == ST_ACTIVE)  && (state_nxt_s == ST_DONE);
    assign rd_go_s    = (state_r == ST_ACTIVE)  && (state_nxt_s == ST_RD_WAIT);
    assign drive_go_s = (state_r == ST_RD_WAIT) && (state_nxt_s == ST_RD_DRIVE);

    // State, read-latency counter and all registered outputs; oe follows the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 3'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wr_data_r <= 16'h0000;
            wr_be_r   <= 2'b00;
            wr_stb_r  <= 1'b0;
            rd_stb_r  <= 1'b0;
            ad_out_r  <= 16'h0000;
            ad_oe_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_stb_r <= wr_go_s;
            rd_stb_r <= rd_go_s;
            ad_oe_r  <= (state_nxt_s == ST_RD_DRIVE);
            if (state_r == ST_RD_WAIT) lat_cnt_r <= lat_cnt_r + 3'd1;
            else                       lat_cnt_r <= 3'd0;
            if (addr_go_s) addr_r <= ad_al_s[ADDR_W-1:0];
            if (wr_go_s) begin
                wr_data_r <= ad_al_s;
                wr_be_r   <= ~ben_al_s;
            end
            if (drive_go_s) ad_out_r <= reg_rd_data;
        end
    end

    assign reg_addr    = addr_r;
    assign reg_wr_stb  = wr_stb_r;
    assign reg_wr_data = wr_data_r;
    assign reg_wr_be   = wr_be_r;
    assign reg_rd_stb  = rd_stb_r;
    assign gpmc_ad_out = ad_out_r;
    assign gpmc_ad_oe  = ad_oe_r;

endmodule

// File: tb/tb_gpmc_async_slave.sv
// Bench for gpmc_async_slave: pin-level host model driving two instances (read latency 1 and 3)
// with a register-file model and a write scoreboard.
module tb_gpmc_async_slave;

    localparam int SYNC_STAGES = 2;

    typedef struct { logic [15:0] addr; logic [15:0] data; logic [1:0] be; } wr_rec_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; logic [1:0] ben; logic [1:0] exp_be; } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csn = 1'b1, advn = 1'b1, oen = 1'b1, wen = 1'b1;
    logic [1:0]  ben = 2'b11;
    logic [15:0] host_ad = 16'h0000;

    logic [15:0] pad1, out1, addr1, wr_data1, rd_data1;
    logic [15:0] pad3, out3, addr3, wr_data3, rd_data3;
    logic [1:0]  wr_be1, wr_be3;
    logic        oe1, wr_stb1, rd_stb1, oe3, wr_stb3, rd_stb3;
    logic [3:0]  v1 = 4'd0, v3 = 4'd0;
    logic [15:0] rd_mem [16];

    wr_rec_t     act_q[$], exp_q[$];
    vec_t        vecs [6];
    int          errors = 0, checks = 0;
    int          rd_cnt1 = 0, rd_cnt3 = 0, oe_bad = 0;
    logic [15:0] last_addr = 16'h0000;

    always #5 clk = ~clk;

    assign pad1 = oe1 ? out1 : host_ad;
    assign pad3 = oe3 ? out3 : host_ad;

    gpmc_async_slave #(.ADDR_W(16), .SYNC_STAGES(SYNC_STAGES), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_oen(oen), .gpmc_wen(wen),
        .gpmc_ben(ben), .gpmc_ad_in(pad1), .gpmc_ad_out(out1), .gpmc_ad_oe(oe1),
        .reg_addr(addr1), .reg_wr_stb(wr_stb1), .reg_wr_data(wr_data1), .reg_wr_be(wr_be1),
        .reg_rd_stb(rd_stb1), .reg_rd_data(rd_data1));

    gpmc_async_slave #(.ADDR_W(16), .SYNC_STAGES(SYNC_STAGES), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_oen(oen), .gpmc_wen(wen),
        .gpmc_ben(ben), .gpmc_ad_in(pad3), .gpmc_ad_out(out3), .gpmc_ad_oe(oe3),
        .reg_addr(addr3), .reg_wr_stb(wr_stb3), .reg_wr_data(wr_data3), .reg_wr_be(wr_be3),
        .reg_rd_stb(rd_stb3), .reg_rd_data(rd_data3));

    // Register file: data is valid only in the single cycle RD_LATENCY after the strobe
    always @(posedge clk) begin
        v1 <= {v1[2:0], rd_stb1};
        v3 <= {v3[2:0], rd_stb3};
    end
    assign rd_data1 = v1[0] ? rd_mem[addr1[3:0]] : 16'hDEAD;
    assign rd_data3 = v3[2] ? rd_mem[addr3[3:0]] : 16'hDEAD;

    // Monitor: every cycle a write strobe is seen becomes one scoreboard entry
    always @(negedge clk) begin
        if (wr_stb1) act_q.push_back('{addr1, wr_data1, wr_be1});
        if (rd_stb1) rd_cnt1++;
        if (rd_stb3) rd_cnt3++;
        if ((oe1 || oe3) && (!wen || !advn)) oe_bad++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_max(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d cycles, limit %0d", name, act, lim);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_L1"}, {wr_stb1, rd_stb1, addr1, wr_data1, wr_be1, out1, oe1}, 64'd0);
        chk({tag, "_L3"}, {wr_stb3, rd_stb3, addr3, wr_data3, wr_be3, out3, oe3}, 64'd0);
    endtask

    task automatic compare_writes(input string tag);
        wr_rec_t e, a;
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            chk({tag, "_addr"}, a.addr, e.addr);
            chk({tag, "_data"}, a.data, e.data);
            chk({tag, "_be"}, a.be, e.be);
        end
        exp_q.delete();
        act_q.delete();
    endtask

    // Host write16; called at a negedge, leaves CS high for exactly gap cycles
    task automatic write16(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b, input int gap);
        csn = 1'b0; advn = 1'b0; host_ad = a; ben = b;
        repeat (3) @(negedge clk);
        advn = 1'b1;
        repeat (2) @(negedge clk);
        host_ad = d; wen = 1'b0;
        repeat (3) @(negedge clk);
        wen = 1'b1;
        repeat (2) @(negedge clk);
        csn = 1'b1; host_ad = 16'($urandom);
        repeat (gap) @(negedge clk);
        last_addr = a;
    endtask

    task automatic read16(input logic [15:0] a, input logic [15:0] exp, input int gap);
        logic [15:0] d1, d3;
        logic        got1, got3;
        int          k1, k3;
        csn = 1'b0; advn = 1'b0; host_ad = a; ben = 2'b00;
        repeat (3) @(negedge clk);
        advn = 1'b1;
        repeat (2) @(negedge clk);
        host_ad = 16'($urandom);
        rd_cnt1 = 0; rd_cnt3 = 0;
        chk("rd_oe_before_oen", {oe1, oe3}, 64'd0);
        oen = 1'b0;
        got1 = 1'b0; got3 = 1'b0; d1 = 16'h0; d3 = 16'h0;
        for (int i = 0; i < 24 && !(got1 && got3); i++) begin
            @(negedge clk);
            if (oe1 && !got1) begin d1 = pad1; got1 = 1'b1; end
            if (oe3 && !got3) begin d3 = pad3; got3 = 1'b1; end
        end
        chk("rd_oe_seen", {got1, got3}, 64'd3);
        chk("rd_data_L1", d1, exp);
        chk("rd_data_L3", d3, exp);
        @(negedge clk);
        oen = 1'b1;
        k1 = 99; k3 = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!oe1 && k1 == 99) k1 = i;
            if (!oe3 && k3 == 99) k3 = i;
        end
        chk_max("rd_oe_release_L1", k1, SYNC_STAGES + 1);
        chk_max("rd_oe_release_L3", k3, SYNC_STAGES + 1);
        chk("rd_stb_once", {rd_cnt1[7:0], rd_cnt3[7:0]}, 64'h0101);
        csn = 1'b1; host_ad = 16'($urandom);
        repeat (gap) @(negedge clk);
        last_addr = a;
    endtask

    initial begin
        logic [15:0] a, d;
        logic [1:0]  b;

        for (int i = 0; i < 16; i++) rd_mem[i] = 16'($urandom);
        rd_mem[9] = 16'h0CCC;
        vecs[0] = '{16'h0008, 16'h001F, 2'b00, 2'b11};
        vecs[1] = '{16'h0008, 16'h0020, 2'b00, 2'b11};
        vecs[2] = '{16'h0009, 16'h0AAA, 2'b00, 2'b11};
        vecs[3] = '{16'h0008, 16'h12AB, 2'b10, 2'b01};
        vecs[4] = '{16'hBEEF, 16'h5A5A, 2'b01, 2'b10};
        vecs[5] = '{16'hFFFF, 16'h0000, 2'b11, 2'b00};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of writes, all back-to-back with a one-cycle CS-high gap
        foreach (vecs[i]) begin
            exp_q.push_back('{vecs[i].addr, vecs[i].data, vecs[i].exp_be});
            write16(vecs[i].addr, vecs[i].data, vecs[i].ben, 1);
        end
        repeat (4) @(negedge clk);
        compare_writes("table_wr");
        chk("table_last_addr", addr1, last_addr);

        read16(16'h0009, 16'h0CCC, 3);
        chk("read_addr", addr1, 16'h0009);

        // CS pulse with no address phase: nothing happens, address is kept
        rd_cnt1 = 0;
        csn = 1'b0;
        repeat (3) @(negedge clk);
        csn = 1'b1;
        repeat (6) @(negedge clk);
        chk("csn_pulse_no_wr", act_q.size(), 64'd0);
        chk("csn_pulse_no_rd", rd_cnt1, 64'd0);
        chk("csn_pulse_addr", addr1, last_addr);

        // Reset during the WE-low phase of a write to 0x8
        csn = 1'b0; advn = 1'b0; host_ad = 16'h0008; ben = 2'b00;
        repeat (3) @(negedge clk);
        advn = 1'b1;
        repeat (2) @(negedge clk);
        host_ad = 16'h4321; wen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("mid_write_reset");
        rst = 1'b0;
        last_addr = 16'h0000;
        repeat (2) @(negedge clk);
        wen = 1'b1;
        repeat (3) @(negedge clk);
        csn = 1'b1;
        repeat (4) @(negedge clk);
        chk("aborted_no_wr", act_q.size(), 64'd0);
        chk("aborted_addr", addr1, last_addr);
        exp_q.push_back('{16'h0008, 16'h0F00, 2'b11});
        write16(16'h0008, 16'h0F00, 2'b00, 2);
        repeat (4) @(negedge clk);
        compare_writes("post_reset_wr");

        // Random mix checked against the bus-level model
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                b = 2'($urandom_range(0, 3));
                exp_q.push_back('{a, d, ~b});
                write16(a, d, b, $urandom_range(1, 3));
            end else begin
                read16(a, rd_mem[a[3:0]], $urandom_range(1, 3));
            end
        end
        repeat (4) @(negedge clk);
        compare_writes("rand_wr");
        chk("rand_last_addr", addr1, last_addr);
        chk("oe_while_wen_or_advn_low", oe_bad, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
